// File: rtl/de_md_reg.sv
// D/E pipeline register with multiply/divide structural stall, bubble insertion and Req flush.
// Optional build macro MD_STALL_STATS_EN adds a saturating md_stall edge counter (md_stall_cnt).
module de_md_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter int          MD_OP_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Req,
    input  logic [31:0]        D_PC,
    input  logic [31:0]        D_Instr,
    input  logic [31:0]        D_RS_val,
    input  logic [31:0]        D_RT_val,
    input  logic [4:0]         D_ExcCode,
    input  logic               D_BD,
    input  logic [MD_OP_W-1:0] D_MDOp,
    input  logic               D_MDStart,
    input  logic               D_MDWrite,
    input  logic               D_MDRead,
    input  logic               D_MDsel,
    input  logic               stall_in,
    input  logic               E_Busy,
    output logic               D_stall,
    output logic [31:0]        E_PC,
    output logic [31:0]        E_Instr,
    output logic [31:0]        E_RS_val,
    output logic [31:0]        E_RT_val,
    output logic [4:0]         E_ExcCode,
    output logic               E_BD,
    output logic [MD_OP_W-1:0] E_MDOp,
    output logic               E_Start,
    output logic               E_MDWrite,
    output logic               E_MDsel,
`ifdef MD_STALL_STATS_EN
    output logic [31:0]        md_stall_cnt,
`endif
    output logic               E_valid
);

    logic md_use;
    logic md_stall;

    // A registered Start counts as busy: the unit only raises Busy the cycle after it sees Start.
    assign md_use   = D_MDStart | D_MDWrite | D_MDRead;
    assign md_stall = md_use & (E_Start | E_Busy);
    assign D_stall  = stall_in | md_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_PC      <= RESET_PC;
            E_BD      <= 1'b0;
            E_Instr   <= '0;
            E_RS_val  <= '0;
            E_RT_val  <= '0;
            E_ExcCode <= '0;
            E_MDOp    <= '0;
            E_Start   <= 1'b0;
            E_MDWrite <= 1'b0;
            E_MDsel   <= 1'b0;
            E_valid   <= 1'b0;
        end else if (Req) begin
            E_PC      <= EXC_PC;
            E_BD      <= 1'b0;
            E_Instr   <= '0;
            E_RS_val  <= '0;
            E_RT_val  <= '0;
            E_ExcCode <= '0;
            E_MDOp    <= '0;
            E_Start   <= 1'b0;
            E_MDWrite <= 1'b0;
            E_MDsel   <= 1'b0;
            E_valid   <= 1'b0;
        end else if (D_stall) begin
            // Bubble keeps PC/BD so an exception taken on it still reports the right EPC.
            E_PC      <= D_PC;
            E_BD      <= D_BD;
            E_Instr   <= '0;
            E_RS_val  <= '0;
            E_RT_val  <= '0;
            E_ExcCode <= '0;
            E_MDOp    <= '0;
            E_Start   <= 1'b0;
            E_MDWrite <= 1'b0;
            E_MDsel   <= 1'b0;
            E_valid   <= 1'b0;
        end else begin
            E_PC      <= D_PC;
            E_BD      <= D_BD;
            E_Instr   <= D_Instr;
            E_RS_val  <= D_RS_val;
            E_RT_val  <= D_RT_val;
            E_ExcCode <= D_ExcCode;
            E_MDOp    <= D_MDOp;
            E_Start   <= D_MDStart;
            E_MDWrite <= D_MDWrite;
            E_MDsel   <= D_MDsel;
            E_valid   <= 1'b1;
        end
    end

`ifdef MD_STALL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_stall_cnt <= '0;
        end else if (md_stall && !Req && (md_stall_cnt != 32'hFFFF_FFFF)) begin
            md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_de_md_reg.sv
// Directed self-checking bench for de_md_reg; md_stall_cnt checks compile in with MD_STALL_STATS_EN.
module tb_de_md_reg;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [31:0] D_PC, D_Instr, D_RS_val, D_RT_val;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic [2:0]  D_MDOp;
    logic        D_MDStart, D_MDWrite, D_MDRead, D_MDsel;
    logic        stall_in, E_Busy;
    logic        D_stall;
    logic [31:0] E_PC, E_Instr, E_RS_val, E_RT_val;
    logic [4:0]  E_ExcCode;
    logic        E_BD;
    logic [2:0]  E_MDOp;
    logic        E_Start, E_MDWrite, E_MDsel, E_valid;
`ifdef MD_STALL_STATS_EN
    logic [31:0] md_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int stall_seen;

    de_md_reg dut (
        .clk(clk), .reset(reset), .Req(Req),
        .D_PC(D_PC), .D_Instr(D_Instr), .D_RS_val(D_RS_val), .D_RT_val(D_RT_val),
        .D_ExcCode(D_ExcCode), .D_BD(D_BD), .D_MDOp(D_MDOp),
        .D_MDStart(D_MDStart), .D_MDWrite(D_MDWrite), .D_MDRead(D_MDRead), .D_MDsel(D_MDsel),
        .stall_in(stall_in), .E_Busy(E_Busy), .D_stall(D_stall),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_RS_val(E_RS_val), .E_RT_val(E_RT_val),
        .E_ExcCode(E_ExcCode), .E_BD(E_BD), .E_MDOp(E_MDOp), .E_Start(E_Start),
        .E_MDWrite(E_MDWrite), .E_MDsel(E_MDsel),
`ifdef MD_STALL_STATS_EN
        .md_stall_cnt(md_stall_cnt),
`endif
        .E_valid(E_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] pc, input logic [31:0] instr,
                         input logic start, input logic wr, input logic rd, input logic bd);
        D_PC = pc; D_Instr = instr; D_MDStart = start; D_MDWrite = wr; D_MDRead = rd; D_BD = bd;
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; stall_in = 1'b0; E_Busy = 1'b0;
        D_PC = '0; D_Instr = '0; D_RS_val = '0; D_RT_val = '0; D_ExcCode = '0;
        D_BD = 1'b0; D_MDOp = '0; D_MDStart = 1'b0; D_MDWrite = 1'b0; D_MDRead = 1'b0; D_MDsel = 1'b0;
        #2;
        check("rst_pc", E_PC, 32'h0000_3000);
        check("rst_valid", {31'd0, E_valid}, 32'd0);
        check("rst_start", {31'd0, E_Start}, 32'd0);
        check("rst_dstall", {31'd0, D_stall}, 32'd0);
        tick();
        #2 reset = 1'b0;
        @(negedge clk);

        // normal pass: addu
        set_d(32'h0000_3004, 32'h0085_1021, 1'b0, 1'b0, 1'b0, 1'b0);
        D_RS_val = 32'h0000_0011; D_RT_val = 32'h0000_0022;
        tick();
        check("pass_pc", E_PC, 32'h0000_3004);
        check("pass_valid", {31'd0, E_valid}, 32'd1);
        check("pass_start", {31'd0, E_Start}, 32'd0);
        check("pass_instr", E_Instr, 32'h0085_1021);
        check("pass_rt", E_RT_val, 32'h0000_0022);

        // mult then mfhi in a delay slot
        set_d(32'h0000_3008, 32'h0085_0018, 1'b1, 1'b0, 1'b0, 1'b0);
        D_MDOp = 3'd1;
        tick();
        check("mult_start", {31'd0, E_Start}, 32'd1);
        check("mult_op", {29'd0, E_MDOp}, 32'd1);
        set_d(32'h0000_300C, 32'h0000_4010, 1'b0, 1'b0, 1'b1, 1'b1);
        D_MDOp = 3'd0; D_MDsel = 1'b1;
        stall_seen = 0;
        for (int i = 1; i <= 8 && D_stall; i++) begin
            stall_seen++;
            tick();
            check("b2b_bub_pc", E_PC, 32'h0000_300C);
            check("b2b_bub_bd", {31'd0, E_BD}, 32'd1);
            check("b2b_bub_valid", {31'd0, E_valid}, 32'd0);
            check("b2b_bub_start", {31'd0, E_Start}, 32'd0);
            if (i == 1) E_Busy = 1'b1;
            if (i == 6) E_Busy = 1'b0;
            #1;
        end
        check("b2b_stall_cycles", stall_seen, 32'd6);
        tick();
        check("b2b_issue_pc", E_PC, 32'h0000_300C);
        check("b2b_issue_valid", {31'd0, E_valid}, 32'd1);
        check("b2b_issue_sel", {31'd0, E_MDsel}, 32'd1);
`ifdef MD_STALL_STATS_EN
        check("b2b_cnt", md_stall_cnt, 32'd6);
`endif

        // Req flush with div in D
        set_d(32'h0000_3010, 32'h0085_001A, 1'b1, 1'b0, 1'b0, 1'b0);
        D_MDOp = 3'd3; D_MDsel = 1'b0;
        Req = 1'b1;
        tick();
        check("req_pc", E_PC, 32'h0000_4180);
        check("req_start", {31'd0, E_Start}, 32'd0);
        check("req_valid", {31'd0, E_valid}, 32'd0);
        Req = 1'b0;

        // Req while md_stall
        tick();
        check("div_start", {31'd0, E_Start}, 32'd1);
        set_d(32'h0000_3014, 32'h0000_2012, 1'b0, 1'b0, 1'b1, 1'b0);
        Req = 1'b1;
        #1;
        check("req_md_dstall", {31'd0, D_stall}, 32'd1);
        tick();
        check("req_md_pc", E_PC, 32'h0000_4180);
        check("req_md_bd", {31'd0, E_BD}, 32'd0);
`ifdef MD_STALL_STATS_EN
        check("req_md_cnt", md_stall_cnt, 32'd6);
`endif
        Req = 1'b0;

        // other-hazard stall with mtlo
        set_d(32'h0000_3018, 32'h0080_0013, 1'b0, 1'b1, 1'b0, 1'b0);
        stall_in = 1'b1;
        tick();
        check("haz_pc", E_PC, 32'h0000_3018);
        check("haz_mdwrite", {31'd0, E_MDWrite}, 32'd0);
        check("haz_valid", {31'd0, E_valid}, 32'd0);
        stall_in = 1'b0;
        tick();
        check("mtlo_mdwrite", {31'd0, E_MDWrite}, 32'd1);
        check("mtlo_valid", {31'd0, E_valid}, 32'd1);

        // nonzero ExcCode still loads and propagates Start
        set_d(32'h0000_301C, 32'h0085_0019, 1'b1, 1'b0, 1'b0, 1'b0);
        D_ExcCode = 5'd10;
        tick();
        check("exc_code", {27'd0, E_ExcCode}, 32'd10);
        check("exc_start", {31'd0, E_Start}, 32'd1);
        D_ExcCode = 5'd0;

        // async reset between edges, D_stall still combinational
        set_d(32'h0000_3020, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        stall_in = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pc", E_PC, 32'h0000_3000);
        check("mid_rst_valid", {31'd0, E_valid}, 32'd0);
        check("mid_rst_start", {31'd0, E_Start}, 32'd0);
        check("mid_rst_dstall", {31'd0, D_stall}, 32'd1);
`ifdef MD_STALL_STATS_EN
        check("mid_rst_cnt", md_stall_cnt, 32'd0);
`endif
        tick();
        check("rst_hold_pc", E_PC, 32'h0000_3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/de_md_reg.md
Name: de_md_reg

Overview:
- D/E pipeline register for the P7 five-stage CPU; feeds the E-stage multiply/divide unit and ALU.
- Latches decoded D-stage fields into E-stage registers.
- Generates the multiply/divide structural stall from the unit's Busy and its own registered Start.
- Inserts bubbles on stall and flushes on exception request, preserving PC/BD for EPC.

Parameters:
RESET_PC, 32'h0000_3000, PC value held by the reset bubble
EXC_PC, 32'h0000_4180, PC value loaded into the bubble on Req flush
MD_OP_W, 3, width of the multiply/divide opcode field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Req  input  1  exception/interrupt request; flush E this cycle
D_PC  input  32  D-stage PC
D_Instr  input  32  D-stage instruction word
D_RS_val  input  32  forwarded rs operand
D_RT_val  input  32  forwarded rt operand
D_ExcCode  input  5  exception code detected in F/D
D_BD  input  1  D instruction sits in a delay slot
D_MDOp  input  MD_OP_W  multiply/divide opcode
D_MDStart  input  1  D is mult/multu/div/divu
D_MDWrite  input  1  D is mthi/mtlo
D_MDRead  input  1  D is mfhi/mflo
D_MDsel  input  1  0 = lo, 1 = hi
stall_in  input  1  other hazard stall from the hazard unit
E_Busy  input  1  Busy from the multiply/divide unit
D_stall  output  1  freeze PC and F/D register
E_PC  output  32  E-stage PC
E_Instr  output  32  E-stage instruction word
E_RS_val  output  32  E-stage rs operand; MD1
E_RT_val  output  32  E-stage rt operand; MD2
E_ExcCode  output  5  E-stage exception code
E_BD  output  1  E-stage delay-slot flag
E_MDOp  output  MD_OP_W  MDOp to the multiply/divide unit
E_Start  output  1  Start to the multiply/divide unit
E_MDWrite  output  1  MDWrite to the multiply/divide unit
E_MDsel  output  1  MDsel to the multiply/divide unit
E_valid  output  1  E holds a real instruction, not a bubble

Behaviour:
- md_use = D_MDStart | D_MDWrite | D_MDRead.
- md_stall = md_use & (E_Start | E_Busy). Combinational.
- D_stall = stall_in | md_stall. Combinational; does not depend on Req.
- Bubble contents:
  - Instr, operands, ExcCode, MDOp, Start, MDWrite, MDsel and valid are all 0.
- Reset:
  - Async, highest priority.
  - Loads a bubble with E_PC = RESET_PC and E_BD = 0.
  - D_stall still follows its combinational equation.
- Per-edge priority, highest first:
  1. Req: load bubble, E_PC = EXC_PC, E_BD = 0.
  2. D_stall: load bubble but keep E_PC = D_PC and E_BD = D_BD, so a later exception reports the correct EPC/BD.
  3. Otherwise: load all D fields, E_valid = 1.
- E_Start is high for exactly one cycle per mult/div. This guarantees the unit sees at most one Start.
- Back-to-back MD instructions:
  - Second one stalls in the cycle the first is in E with E_Start = 1.
  - It keeps stalling while E_Busy = 1.
  - It issues on the first edge after E_Busy falls: stall cycles = 1 + busy cycles.
- Simultaneous Req and stall: Req wins and the E bubble takes EXC_PC. D_stall output is unaffected.
- A D-stage ExcCode != 0 does not suppress register load. Start/MDWrite still propagate; the E stage masks them using Req from M.
- No state beyond the E registers, except the optional counter.

Optional Feature:
- Macro: MD_STALL_STATS_EN.
- When defined:
  - Adds output port md_stall_cnt, 32 bits.
  - Counts clock edges where md_stall = 1, reset and Req excluded.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-run:
  - Stimulus: assert reset asynchronously between edges.
  - Response: E_PC = 32'h0000_3000 immediately; E_valid = 0, E_Start = 0.
- Normal pass:
  - Stimulus: D_PC = 32'h0000_3004, addu instruction, no stall.
  - Response: next edge E_PC = 32'h0000_3004, E_valid = 1, E_Start = 0.
- Back-to-back multiply:
  - Stimulus: mult at 32'h0000_3008, then mfhi at 32'h0000_300C; E_Busy high for 5 cycles after Start.
  - Response: mfhi stalls 6 cycles, with bubbles E_PC = 32'h0000_300C, E_BD = D_BD; it enters E the edge after E_Busy falls.
  - With MD_STALL_STATS_EN: md_stall_cnt = 6.
- Req flush:
  - Stimulus: Req with D holding div at 32'h0000_3010.
  - Response: E_PC = 32'h0000_4180, E_Start = 0, E_valid = 0.
- Req while md_stall:
  - Stimulus: Req asserted while md_stall = 1.
  - Response: E_PC = 32'h0000_4180; D_stall stays 1 that cycle.
- Other-hazard stall:
  - Stimulus: stall_in = 1 with D_MDWrite = 1 (mtlo), E_Busy = 0.
  - Response: bubble keeps D_PC; E_MDWrite = 0; mtlo issues the cycle after stall_in drops.
